// File: rtl/uart_rx_fsm.sv
// uart_rx_fsm
//   UART receive state machine. Synchronises the serial line, qualifies the
//   start bit at mid-bit, samples 5..8 data bits LSB first, an optional parity
//   bit and one or two stop bits, then delivers the byte and error pulses.
//
// Parameters
//   OVERSAMPLE   baud_tick pulses per bit period (power of 2, >= 8)
//   SYNC_STAGES  depth of the rx_in synchroniser (>= 2)
//
// Ports
//   PCLK              system clock, rising edge
//   PRESET            asynchronous active-high reset
//   baud_tick         one-PCLK enable, OVERSAMPLE per bit period
//   RXen              receiver enable; low forces IDLE
//   rx_in             asynchronous serial line, idle high
//   number_data_trans data bits per frame (clamped to 5..8)
//   parity_bit_mode   parity bit present
//   parity_odd        odd parity when 1, even when 0
//   stop_bit_twice    two stop bits checked
//   rx_fifo_full      RX FIFO cannot accept a write
//   rx_data           last received byte, zero-extended above N bits
//   ctrl_rx_buffer    one-cycle RX FIFO write strobe
//   bit_count         data bits sampled in the current frame
//   busy              FSM not in IDLE or WAIT_HIGH
//   done_rx           one-cycle frame-complete pulse
//   parity_error      one-cycle pulse with done_rx
//   framing_error     one-cycle pulse with done_rx
//   overrun_error     one-cycle pulse with done_rx
module uart_rx_fsm #(
  parameter int OVERSAMPLE  = 16,
  parameter int SYNC_STAGES = 2
) (
  input  logic       PCLK,
  input  logic       PRESET,
  input  logic       baud_tick,
  input  logic       RXen,
  input  logic       rx_in,
  input  logic [3:0] number_data_trans,
  input  logic       parity_bit_mode,
  input  logic       parity_odd,
  input  logic       stop_bit_twice,
  input  logic       rx_fifo_full,
  output logic [7:0] rx_data,
  output logic       ctrl_rx_buffer,
  output logic [3:0] bit_count,
  output logic       busy,
  output logic       done_rx,
  output logic       parity_error,
  output logic       framing_error,
  output logic       overrun_error
);

  localparam int TW = $clog2(OVERSAMPLE);
  localparam logic [TW-1:0] HALF_LAST = TW'(OVERSAMPLE / 2 - 1);
  localparam logic [TW-1:0] FULL_LAST = TW'(OVERSAMPLE - 1);

  localparam logic [2:0] S_IDLE      = 3'd0;
  localparam logic [2:0] S_START     = 3'd1;
  localparam logic [2:0] S_DATA      = 3'd2;
  localparam logic [2:0] S_PARITY    = 3'd3;
  localparam logic [2:0] S_STOP_0    = 3'd4;
  localparam logic [2:0] S_STOP_1    = 3'd5;
  localparam logic [2:0] S_FINISH    = 3'd6;
  localparam logic [2:0] S_WAIT_HIGH = 3'd7;

  logic [SYNC_STAGES-1:0] sync_q;
  logic                   rx_s;
  logic [2:0]             state;
  logic [TW-1:0]          tick_cnt;
  logic [7:0]             shreg;
  logic [3:0]             n_cfg;
  logic [3:0]             n_lat;
  logic                   par_en_lat;
  logic                   par_odd_lat;
  logic                   stop2_lat;
  logic                   perr;
  logic                   ferr;
  logic                   timing;
  logic                   sample;

  // Synchroniser: the line idles high, so the chain resets to 1
  always_ff @(posedge PCLK or posedge PRESET) begin
    if (PRESET) sync_q <= '1;
    else        sync_q <= {sync_q[SYNC_STAGES-2:0], rx_in};
  end

  assign rx_s = sync_q[SYNC_STAGES-1];

  always_comb begin
    n_cfg = number_data_trans;
    if (number_data_trans < 4'd5)      n_cfg = 4'd5;
    else if (number_data_trans > 4'd8) n_cfg = 4'd8;
  end

  // START samples half a bit after the falling edge; every later sample is a
  // full bit after the previous one, which lands it at mid-bit.
  always_comb begin
    timing = (state == S_START) || (state == S_DATA) || (state == S_PARITY) ||
             (state == S_STOP_0) || (state == S_STOP_1);
    sample = timing && baud_tick &&
             (tick_cnt == ((state == S_START) ? HALF_LAST : FULL_LAST));
  end

  assign busy = (state != S_IDLE) && (state != S_WAIT_HIGH);

  // Frame FSM and output pulses
  always_ff @(posedge PCLK or posedge PRESET) begin
    if (PRESET) begin
      state          <= S_IDLE;
      tick_cnt       <= '0;
      bit_count      <= '0;
      shreg          <= '0;
      rx_data        <= '0;
      n_lat          <= 4'd8;
      par_en_lat     <= 1'b0;
      par_odd_lat    <= 1'b0;
      stop2_lat      <= 1'b0;
      perr           <= 1'b0;
      ferr           <= 1'b0;
      done_rx        <= 1'b0;
      ctrl_rx_buffer <= 1'b0;
      parity_error   <= 1'b0;
      framing_error  <= 1'b0;
      overrun_error  <= 1'b0;
    end else begin
      done_rx        <= 1'b0;
      ctrl_rx_buffer <= 1'b0;
      parity_error   <= 1'b0;
      framing_error  <= 1'b0;
      overrun_error  <= 1'b0;
      if (!RXen) begin
        state     <= S_IDLE;
        tick_cnt  <= '0;
        bit_count <= '0;
      end else begin
        if (timing && baud_tick)
          tick_cnt <= sample ? '0 : tick_cnt + TW'(1);
        case (state)
          S_IDLE: begin
            tick_cnt <= '0;
            if (!rx_s) begin
              state       <= S_START;
              bit_count   <= '0;
              // shreg cleared so bits above N read back as zero
              shreg       <= '0;
              perr        <= 1'b0;
              ferr        <= 1'b0;
              n_lat       <= n_cfg;
              par_en_lat  <= parity_bit_mode;
              par_odd_lat <= parity_odd;
              stop2_lat   <= stop_bit_twice;
            end
          end
          S_START: begin
            if (sample) state <= rx_s ? S_IDLE : S_DATA;
          end
          S_DATA: begin
            if (sample) begin
              shreg[bit_count[2:0]] <= rx_s;
              bit_count             <= bit_count + 4'd1;
              if (bit_count + 4'd1 == n_lat)
                state <= par_en_lat ? S_PARITY : S_STOP_0;
            end
          end
          S_PARITY: begin
            if (sample) begin
              perr  <= ((^shreg) ^ rx_s) != par_odd_lat;
              state <= S_STOP_0;
            end
          end
          S_STOP_0: begin
            if (sample) begin
              if (!rx_s) ferr <= 1'b1;
              state <= stop2_lat ? S_STOP_1 : S_FINISH;
            end
          end
          S_STOP_1: begin
            if (sample) begin
              if (!rx_s) ferr <= 1'b1;
              state <= S_FINISH;
            end
          end
          S_FINISH: begin
            rx_data        <= shreg;
            done_rx        <= 1'b1;
            parity_error   <= perr;
            framing_error  <= ferr;
            ctrl_rx_buffer <= !rx_fifo_full;
            overrun_error  <= rx_fifo_full;
            // A low stop bit may be a break; wait for the line to recover
            state          <= ferr ? S_WAIT_HIGH : S_IDLE;
          end
          default: begin
            if (rx_s) state <= S_IDLE;
          end
        endcase
      end
    end
  end

endmodule

// File: tb/tb_uart_rx_fsm.sv
module tb_uart_rx_fsm;

  localparam int OS     = 16;
  localparam int DIV    = 4;
  localparam int BITCLK = OS * DIV;

  logic       PCLK;
  logic       PRESET;
  logic       baud_tick;
  logic       RXen;
  logic       rx_in;
  logic [3:0] number_data_trans;
  logic       parity_bit_mode;
  logic       parity_odd;
  logic       stop_bit_twice;
  logic       rx_fifo_full;
  logic [7:0] rx_data;
  logic       ctrl_rx_buffer;
  logic [3:0] bit_count;
  logic       busy;
  logic       done_rx;
  logic       parity_error;
  logic       framing_error;
  logic       overrun_error;

  int n_vec = 0;
  int n_err = 0;
  int done_cnt, ctrl_cnt, perr_cnt, ferr_cnt, oerr_cnt;
  logic [7:0] data_log [0:7];
  logic perr_at_done, ferr_at_done, oerr_at_done;
  int tick_div = 0;

  uart_rx_fsm #(.OVERSAMPLE(OS), .SYNC_STAGES(2)) dut (
    .PCLK              (PCLK),
    .PRESET            (PRESET),
    .baud_tick         (baud_tick),
    .RXen              (RXen),
    .rx_in             (rx_in),
    .number_data_trans (number_data_trans),
    .parity_bit_mode   (parity_bit_mode),
    .parity_odd        (parity_odd),
    .stop_bit_twice    (stop_bit_twice),
    .rx_fifo_full      (rx_fifo_full),
    .rx_data           (rx_data),
    .ctrl_rx_buffer    (ctrl_rx_buffer),
    .bit_count         (bit_count),
    .busy              (busy),
    .done_rx           (done_rx),
    .parity_error      (parity_error),
    .framing_error     (framing_error),
    .overrun_error     (overrun_error)
  );

  initial PCLK = 1'b0;
  always #5 PCLK = ~PCLK;

  // One baud_tick every DIV clocks
  always @(negedge PCLK) begin
    tick_div  = (tick_div == DIV - 1) ? 0 : tick_div + 1;
    baud_tick = (tick_div == 0);
  end

  // Pulse monitor
  always @(negedge PCLK) begin
    if (done_rx) begin
      if (done_cnt < 8) data_log[done_cnt] = rx_data;
      perr_at_done = parity_error;
      ferr_at_done = framing_error;
      oerr_at_done = overrun_error;
      done_cnt++;
    end
    if (ctrl_rx_buffer) ctrl_cnt++;
    if (parity_error)   perr_cnt++;
    if (framing_error)  ferr_cnt++;
    if (overrun_error)  oerr_cnt++;
  end

  task clear_mon();
    @(posedge PCLK);
    done_cnt = 0; ctrl_cnt = 0; perr_cnt = 0; ferr_cnt = 0; oerr_cnt = 0;
    perr_at_done = 1'b0; ferr_at_done = 1'b0; oerr_at_done = 1'b0;
    for (int i = 0; i < 8; i++) data_log[i] = 8'h00;
  endtask

  task set_cfg(input logic [3:0] nb, input logic par, input logic odd, input logic st2);
    number_data_trans = nb;
    parity_bit_mode   = par;
    parity_odd        = odd;
    stop_bit_twice    = st2;
  endtask

  task bit_out(input logic v);
    rx_in = v;
    repeat (BITCLK) @(negedge PCLK);
  endtask

  task send_frame(input logic [7:0] d, input int nb, input logic par_en, input logic par_v,
                  input logic stop0, input logic stop2_en, input logic stop1);
    bit_out(1'b0);
    for (int i = 0; i < nb; i++) bit_out(d[i]);
    if (par_en) bit_out(par_v);
    bit_out(stop0);
    if (stop2_en) bit_out(stop1);
  endtask

  task test_reset();
    PRESET = 1'b1;
    repeat (3) @(negedge PCLK);
    n_vec++; if (busy !== 1'b0) begin n_err++; $display("FAIL reset_busy: got %b want 0", busy); end
    n_vec++; if (rx_data !== 8'h00) begin n_err++; $display("FAIL reset_rx_data: got %h want 00", rx_data); end
    n_vec++; if (bit_count !== 4'd0) begin n_err++; $display("FAIL reset_bit_count: got %0d want 0", bit_count); end
    n_vec++; if (done_rx !== 1'b0) begin n_err++; $display("FAIL reset_done: got %b want 0", done_rx); end
    n_vec++; if (ctrl_rx_buffer !== 1'b0) begin n_err++; $display("FAIL reset_ctrl: got %b want 0", ctrl_rx_buffer); end
    n_vec++; if ({parity_error, framing_error, overrun_error} !== 3'b000) begin
      n_err++; $display("FAIL reset_flags: got %b want 000", {parity_error, framing_error, overrun_error}); end
    PRESET = 1'b0;
    repeat (10) @(negedge PCLK);
    // Partial frame then asynchronous reset
    bit_out(1'b0); bit_out(1'b1); bit_out(1'b0); bit_out(1'b1);
    n_vec++; if (bit_count !== 4'd3) begin n_err++; $display("FAIL midframe_bit_count: got %0d want 3", bit_count); end
    #2 PRESET = 1'b1;
    #1;
    n_vec++; if (busy !== 1'b0) begin n_err++; $display("FAIL async_reset_busy: got %b want 0", busy); end
    n_vec++; if (bit_count !== 4'd0) begin n_err++; $display("FAIL async_reset_bit_count: got %0d want 0", bit_count); end
    rx_in = 1'b1;
    repeat (4) @(negedge PCLK);
    PRESET = 1'b0;
    repeat (10) @(negedge PCLK);
  endtask

  task test_8n1();
    clear_mon();
    set_cfg(4'd8, 1'b0, 1'b0, 1'b0);
    send_frame(8'hA5, 8, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1);
    repeat (20) @(negedge PCLK);
    n_vec++; if (done_cnt !== 1) begin n_err++; $display("FAIL 8n1_done_count: got %0d want 1", done_cnt); end
    n_vec++; if (ctrl_cnt !== 1) begin n_err++; $display("FAIL 8n1_ctrl_count: got %0d want 1", ctrl_cnt); end
    n_vec++; if (rx_data !== 8'hA5) begin n_err++; $display("FAIL 8n1_rx_data: got %h want a5", rx_data); end
    n_vec++; if (perr_cnt + ferr_cnt + oerr_cnt !== 0) begin
      n_err++; $display("FAIL 8n1_flags: got %0d error pulses want 0", perr_cnt + ferr_cnt + oerr_cnt); end
    n_vec++; if (bit_count !== 4'd8) begin n_err++; $display("FAIL 8n1_bit_count: got %0d want 8", bit_count); end
    n_vec++; if (busy !== 1'b0) begin n_err++; $display("FAIL 8n1_busy: got %b want 0", busy); end
  endtask

  task test_parity();
    // 0x35 in 7 bits has four ones: even parity bit should be 0, so 1 is wrong
    clear_mon();
    set_cfg(4'd7, 1'b1, 1'b0, 1'b0);
    send_frame(8'h35, 7, 1'b1, 1'b1, 1'b1, 1'b0, 1'b1);
    repeat (20) @(negedge PCLK);
    n_vec++; if (done_cnt !== 1) begin n_err++; $display("FAIL par_even_done: got %0d want 1", done_cnt); end
    n_vec++; if (perr_at_done !== 1'b1) begin n_err++; $display("FAIL par_even_perr: got %b want 1", perr_at_done); end
    n_vec++; if (rx_data !== 8'h35) begin n_err++; $display("FAIL par_even_rx_data: got %h want 35", rx_data); end
    // Odd parity with the same bit 1 gives five ones: correct
    clear_mon();
    set_cfg(4'd7, 1'b1, 1'b1, 1'b0);
    send_frame(8'h35, 7, 1'b1, 1'b1, 1'b1, 1'b0, 1'b1);
    repeat (20) @(negedge PCLK);
    n_vec++; if (done_cnt !== 1) begin n_err++; $display("FAIL par_odd_done: got %0d want 1", done_cnt); end
    n_vec++; if (perr_cnt !== 0) begin n_err++; $display("FAIL par_odd_perr: got %0d pulses want 0", perr_cnt); end
  endtask

  task test_glitch();
    clear_mon();
    set_cfg(4'd8, 1'b0, 1'b0, 1'b0);
    rx_in = 1'b0;
    repeat (12) @(negedge PCLK);
    n_vec++; if (busy !== 1'b1) begin n_err++; $display("FAIL glitch_busy_start: got %b want 1", busy); end
    repeat (4) @(negedge PCLK);
    rx_in = 1'b1;
    repeat (80) @(negedge PCLK);
    n_vec++; if (busy !== 1'b0) begin n_err++; $display("FAIL glitch_busy_end: got %b want 0", busy); end
    n_vec++; if (done_cnt + ferr_cnt + perr_cnt !== 0) begin
      n_err++; $display("FAIL glitch_pulses: got %0d pulses want 0", done_cnt + ferr_cnt + perr_cnt); end
  endtask

  task test_break();
    clear_mon();
    set_cfg(4'd8, 1'b0, 1'b0, 1'b1);
    send_frame(8'h3C, 8, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0);
    rx_in = 1'b0;
    repeat (3 * 11 * BITCLK) @(negedge PCLK);
    n_vec++; if (done_cnt !== 1) begin n_err++; $display("FAIL break_done: got %0d want 1", done_cnt); end
    n_vec++; if (ferr_cnt !== 1) begin n_err++; $display("FAIL break_ferr_count: got %0d want 1", ferr_cnt); end
    n_vec++; if (ferr_at_done !== 1'b1) begin n_err++; $display("FAIL break_ferr_at_done: got %b want 1", ferr_at_done); end
    n_vec++; if (rx_data !== 8'h3C) begin n_err++; $display("FAIL break_rx_data: got %h want 3c", rx_data); end
    n_vec++; if (busy !== 1'b0) begin n_err++; $display("FAIL break_busy: got %b want 0", busy); end
    rx_in = 1'b1;
    repeat (2 * BITCLK) @(negedge PCLK);
    set_cfg(4'd8, 1'b0, 1'b0, 1'b0);
    send_frame(8'h81, 8, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1);
    repeat (20) @(negedge PCLK);
    n_vec++; if (done_cnt !== 2) begin n_err++; $display("FAIL break_recover_done: got %0d want 2", done_cnt); end
    n_vec++; if (rx_data !== 8'h81) begin n_err++; $display("FAIL break_recover_data: got %h want 81", rx_data); end
  endtask

  task test_overrun();
    clear_mon();
    set_cfg(4'd8, 1'b0, 1'b0, 1'b0);
    rx_fifo_full = 1'b1;
    send_frame(8'h5A, 8, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1);
    repeat (20) @(negedge PCLK);
    rx_fifo_full = 1'b0;
    n_vec++; if (done_cnt !== 1) begin n_err++; $display("FAIL ovr_done: got %0d want 1", done_cnt); end
    n_vec++; if (ctrl_cnt !== 0) begin n_err++; $display("FAIL ovr_ctrl: got %0d want 0", ctrl_cnt); end
    n_vec++; if (oerr_at_done !== 1'b1) begin n_err++; $display("FAIL ovr_flag: got %b want 1", oerr_at_done); end
    n_vec++; if (rx_data !== 8'h5A) begin n_err++; $display("FAIL ovr_rx_data: got %h want 5a", rx_data); end
  endtask

  task test_short_frame();
    clear_mon();
    set_cfg(4'd3, 1'b0, 1'b0, 1'b0);
    send_frame(8'h15, 5, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1);
    repeat (20) @(negedge PCLK);
    n_vec++; if (rx_data !== 8'h15) begin n_err++; $display("FAIL short_rx_data: got %h want 15", rx_data); end
    n_vec++; if (done_cnt !== 1) begin n_err++; $display("FAIL short_done: got %0d want 1", done_cnt); end
    // Next frame aborted by RXen after three data bits
    clear_mon();
    bit_out(1'b0); bit_out(1'b0); bit_out(1'b1); bit_out(1'b0);
    n_vec++; if (bit_count !== 4'd3) begin n_err++; $display("FAIL abort_bit_count_pre: got %0d want 3", bit_count); end
    RXen = 1'b0;
    repeat (2) @(negedge PCLK);
    n_vec++; if (busy !== 1'b0) begin n_err++; $display("FAIL abort_busy: got %b want 0", busy); end
    n_vec++; if (bit_count !== 4'd0) begin n_err++; $display("FAIL abort_bit_count: got %0d want 0", bit_count); end
    bit_out(1'b1); bit_out(1'b0); bit_out(1'b1);
    RXen = 1'b1;
    repeat (40) @(negedge PCLK);
    n_vec++; if (done_cnt + ctrl_cnt !== 0) begin
      n_err++; $display("FAIL abort_strobes: got %0d strobes want 0", done_cnt + ctrl_cnt); end
    n_vec++; if (rx_data !== 8'h15) begin n_err++; $display("FAIL abort_rx_data: got %h want 15", rx_data); end
  endtask

  task test_back_to_back();
    clear_mon();
    set_cfg(4'd8, 1'b0, 1'b0, 1'b0);
    send_frame(8'h12, 8, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1);
    send_frame(8'hEF, 8, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1);
    repeat (20) @(negedge PCLK);
    n_vec++; if (done_cnt !== 2) begin n_err++; $display("FAIL b2b_done: got %0d want 2", done_cnt); end
    n_vec++; if (ctrl_cnt !== 2) begin n_err++; $display("FAIL b2b_ctrl: got %0d want 2", ctrl_cnt); end
    n_vec++; if (data_log[0] !== 8'h12) begin n_err++; $display("FAIL b2b_first: got %h want 12", data_log[0]); end
    n_vec++; if (data_log[1] !== 8'hEF) begin n_err++; $display("FAIL b2b_second: got %h want ef", data_log[1]); end
  endtask

  initial begin
    PRESET = 1'b1;
    baud_tick = 1'b0;
    RXen = 1'b1;
    rx_in = 1'b1;
    rx_fifo_full = 1'b0;
    set_cfg(4'd8, 1'b0, 1'b0, 1'b0);
    done_cnt = 0; ctrl_cnt = 0; perr_cnt = 0; ferr_cnt = 0; oerr_cnt = 0;
    test_reset();
    test_8n1();
    test_parity();
    test_glitch();
    test_break();
    test_overrun();
    test_short_frame();
    test_back_to_back();
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
